// File: rtl/dm_host_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_host_loader_pkg
// Brief    : Shared constants and the load/run/drain state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package dm_host_loader_pkg;

    localparam int c_dm_addr_w  = 16;
    localparam int c_dm_data_w  = 8;
    localparam int c_proc_bus_w = 24;
    localparam int c_cnt_w      = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dm_host_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_host_loader_if
// Brief    : Host load/result streams and the data-memory port.
// Revision : 1.0 - initial release
// ============================================================================
interface dm_host_loader_if
    import dm_host_loader_pkg::*;
#(
    parameter int ADDR_W = c_dm_addr_w,
    parameter int DATA_W = c_dm_data_w
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_we;
    logic              dm_re;
    logic [DATA_W-1:0] dm_rdata;

    // master = host + memory side, slave = the loader
    modport master (
        output in_valid, in_data, out_ready, dm_rdata,
        input  in_ready, out_valid, out_data, dm_addr, dm_wdata, dm_we, dm_re
    );
    modport slave (
        input  in_valid, in_data, out_ready, dm_rdata,
        output in_ready, out_valid, out_data, dm_addr, dm_wdata, dm_we, dm_re
    );
endinterface
`default_nettype wire

// File: rtl/dm_host_loader_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dm_out_buffer
// Brief    : 2-entry valid/ready FIFO absorbing the memory read latency.
// Revision : 1.0 - initial release
// ============================================================================
module dm_out_buffer
    import dm_host_loader_pkg::*;
#(
    parameter int DATA_W = c_dm_data_w
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_pop;

    assign w_pop     = (r_count != 2'd0) & out_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/dm_host_loader.sv
`default_nettype none
// ============================================================================
// Module   : dm_host_loader
// Brief    : Loads operands into data memory, runs the processor, drains results.
// Revision : 1.0 - initial release
// ============================================================================
module dm_host_loader
    import dm_host_loader_pkg::*;
#(
    parameter int ADDR_W = c_dm_addr_w,
    parameter int DATA_W = c_dm_data_w,
    parameter int CNT_W  = c_cnt_w
) (
    input  logic                    clock,
    input  logic                    rst,
    dm_host_loader_if.slave         bus,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       load_len,
    input  logic [ADDR_W-1:0]       out_base,
    input  logic [ADDR_W-1:0]       out_len,
    output logic                    proc_rst_n,
    input  logic                    proc_dm_en,
    input  logic [ADDR_W-1:0]       proc_ar,
    input  logic [c_proc_bus_w-1:0] proc_bus,
    input  logic                    proc_end,
    output logic [DATA_W-1:0]       proc_dm_out,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        run_cycles
);
    localparam logic [ADDR_W-1:0] c_addr_one = 1;
    localparam logic [CNT_W-1:0]  c_cnt_one  = 1;

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_load_len, r_out_base, r_out_len;
    logic [ADDR_W-1:0] r_ld_ptr, r_rd_cnt, r_pop_cnt;
    logic              r_inflight;
    logic              r_done;
    logic [CNT_W-1:0]  r_run_cycles;

    logic              w_start_ok, w_load_acc, w_load_last;
    logic              w_buf_valid, w_pop, w_rd_issue, w_drain_last;
    logic [DATA_W-1:0] w_buf_data;
    logic [1:0]        w_buf_count, w_pending;
    logic              w_unused_bus;

    assign w_unused_bus = ^proc_bus[c_proc_bus_w-1:DATA_W];

    assign w_start_ok  = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_load_acc  = bus.in_valid & (r_state == ST_LOAD);
    assign w_load_last = w_load_acc & ((r_ld_ptr + c_addr_one) == r_load_len);

    // A new read may issue while a slot is free, counting reads still in flight
    assign w_pop        = w_buf_valid & bus.out_ready;
    assign w_pending    = w_buf_count + {1'b0, r_inflight};
    assign w_rd_issue   = (r_state == ST_DRAIN) & (r_rd_cnt != r_out_len) &
                          ((w_pending < 2'd2) | w_pop);
    assign w_drain_last = (r_out_len == '0) | (w_pop & ((r_pop_cnt + c_addr_one) == r_out_len));

    dm_out_buffer #(.DATA_W(DATA_W)) u_out_buffer (
        .clock     (clock),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (bus.dm_rdata),
        .out_valid (w_buf_valid),
        .out_data  (w_buf_data),
        .out_ready (bus.out_ready),
        .count     (w_buf_count)
    );

    assign bus.out_valid = w_buf_valid;
    assign bus.out_data  = w_buf_data;
    assign done          = r_done;
    assign run_cycles    = r_run_cycles;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next_state = (load_len == '0) ? ST_RUN : ST_LOAD;
            ST_LOAD:          if (w_load_last) w_next_state = ST_RUN;
            ST_RUN:           if (proc_end) w_next_state = ST_DRAIN;
            ST_DRAIN:         if (w_drain_last) w_next_state = ST_DONE;
            default:          w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        bus.dm_we    = 1'b0;
        bus.dm_re    = 1'b0;
        proc_rst_n   = 1'b0;
        proc_dm_out  = '0;
        busy         = 1'b0;
        case (r_state)
            ST_LOAD: begin
                busy         = 1'b1;
                bus.in_ready = 1'b1;
                bus.dm_addr  = r_ld_ptr;
                bus.dm_wdata = bus.in_data;
                bus.dm_we    = bus.in_valid;
            end
            ST_RUN: begin
                busy         = 1'b1;
                proc_rst_n   = 1'b1;
                bus.dm_addr  = proc_ar;
                bus.dm_wdata = proc_bus[DATA_W-1:0];
                bus.dm_we    = proc_dm_en;
                bus.dm_re    = ~proc_dm_en;
                proc_dm_out  = bus.dm_rdata;
            end
            ST_DRAIN: begin
                busy         = 1'b1;
                bus.dm_addr  = r_out_base + r_rd_cnt;
                bus.dm_re    = w_rd_issue;
            end
            default: begin
                busy         = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_load_len   <= '0;
            r_out_base   <= '0;
            r_out_len    <= '0;
            r_ld_ptr     <= '0;
            r_rd_cnt     <= '0;
            r_pop_cnt    <= '0;
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
            r_run_cycles <= '0;
        end else begin
            r_inflight <= w_rd_issue;
            if (w_start_ok) begin
                r_load_len   <= load_len;
                r_out_base   <= out_base;
                r_out_len    <= out_len;
                r_ld_ptr     <= '0;
                r_rd_cnt     <= '0;
                r_pop_cnt    <= '0;
                r_done       <= 1'b0;
                r_run_cycles <= '0;
            end
            if (w_load_acc) begin
                r_ld_ptr <= r_ld_ptr + c_addr_one;
            end
            if ((r_state == ST_RUN) && (r_run_cycles != '1)) begin
                r_run_cycles <= r_run_cycles + c_cnt_one;
            end
            if (w_rd_issue) begin
                r_rd_cnt <= r_rd_cnt + c_addr_one;
            end
            if (w_pop) begin
                r_pop_cnt <= r_pop_cnt + c_addr_one;
            end
            if ((r_state == ST_DRAIN) && w_drain_last) begin
                r_done <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dm_host_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_host_loader
// Brief    : Directed self-checking bench with a 1-cycle-latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_host_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] load_len = '0, out_base = '0, out_len = '0;
    logic        proc_dm_en = 1'b0;
    logic [15:0] proc_ar = '0;
    logic [23:0] proc_bus = '0;
    logic        proc_end = 1'b0;
    logic        proc_rst_n;
    logic [7:0]  proc_dm_out;
    logic        busy, done;
    logic [31:0] run_cycles;

    always #5 clk = ~clk;

    dm_host_loader_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    dm_host_loader #(.ADDR_W(16), .DATA_W(8), .CNT_W(32)) dut (
        .clock       (clk),
        .rst         (rst_n),
        .bus         (bus),
        .start       (start),
        .load_len    (load_len),
        .out_base    (out_base),
        .out_len     (out_len),
        .proc_rst_n  (proc_rst_n),
        .proc_dm_en  (proc_dm_en),
        .proc_ar     (proc_ar),
        .proc_bus    (proc_bus),
        .proc_end    (proc_end),
        .proc_dm_out (proc_dm_out),
        .busy        (busy),
        .done        (done),
        .run_cycles  (run_cycles)
    );

    logic [7:0] mem [0:65535];
    int n_writes = 0;
    int n_valid  = 0;

    always @(posedge clk) begin
        if (bus.dm_we) begin
            mem[bus.dm_addr] <= bus.dm_wdata;
            n_writes <= n_writes + 1;
        end
        if (bus.dm_re) bus.dm_rdata <= mem[bus.dm_addr];
        if (bus.out_valid) n_valid <= n_valid + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] ll, input logic [15:0] ob, input logic [15:0] ol);
        start = 1'b1; load_len = ll; out_base = ob; out_len = ol;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ld_vals [4];
        logic [7:0] wrap_exp [4];
        logic [7:0] hold;
        int         idx, nw, nv;
        logic       stalled;

        ld_vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
        wrap_exp = '{8'hB1, 8'hB2, 8'hA1, 8'hA2};
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready",   bus.in_ready, 0);
        check_eq("rst_out_valid",  bus.out_valid, 0);
        check_eq("rst_out_data",   bus.out_data, 0);
        check_eq("rst_dm_we",      bus.dm_we, 0);
        check_eq("rst_dm_re",      bus.dm_re, 0);
        check_eq("rst_dm_addr",    bus.dm_addr, 0);
        check_eq("rst_dm_wdata",   bus.dm_wdata, 0);
        check_eq("rst_busy",       busy, 0);
        check_eq("rst_done",       done, 0);
        check_eq("rst_run_cycles", run_cycles, 0);
        check_eq("rst_proc_rst_n", proc_rst_n, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a load
        pulse_start(16'd8, 16'h0000, 16'd0);
        check_eq("abort_in_ready_load", bus.in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hE0 + 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("abort_in_ready",   bus.in_ready, 0);
        check_eq("abort_proc_rst_n", proc_rst_n, 0);
        check_eq("abort_busy",       busy, 0);
        #2 rst_n = 1'b1;
        tick();

        // Load with gaps; result region prepared later by the processor
        pulse_start(16'd4, 16'h0020, 16'd4);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b0;
            tick();
            bus.in_valid = 1'b1;
            bus.in_data  = ld_vals[i];
            #1;
            check_eq("load_we",   bus.dm_we, 1);
            check_eq("load_addr", bus.dm_addr, 32'(i));
            tick();
        end
        bus.in_valid = 1'b0;
        check_eq("load_to_run_proc_rst_n", proc_rst_n, 1);
        check_eq("load_to_run_in_ready",   bus.in_ready, 0);
        for (int i = 0; i < 4; i++) check_eq("load_mem", mem[i], ld_vals[i]);

        // Run: write/read-back, prepare results, ignored start, end after 100 cycles
        for (int k = 1; k <= 100; k++) begin
            proc_dm_en = 1'b0; proc_ar = '0; proc_bus = '0; start = 1'b0;
            proc_end = (k == 100);
            if (k == 1) begin proc_dm_en = 1'b1; proc_ar = 16'h0010; proc_bus = 24'h00005A; end
            if (k == 2) proc_ar = 16'h0010;
            if (k >= 3 && k <= 6) begin
                proc_dm_en = 1'b1; proc_ar = 16'h0020 + 16'(k - 3); proc_bus = 24'(k - 2);
            end
            if (k == 10) begin start = 1'b1; load_len = 16'd7; out_base = 16'h0040; out_len = 16'd2; end
            #1;
            if (k == 1) begin
                check_eq("run_we",    bus.dm_we, 1);
                check_eq("run_addr",  bus.dm_addr, 32'h10);
                check_eq("run_wdata", bus.dm_wdata, 32'h5A);
            end
            if (k == 2) check_eq("run_re", bus.dm_re, 1);
            if (k == 3) check_eq("run_readback", proc_dm_out, 32'h5A);
            if (k == 11) check_eq("run_start_ignored", proc_rst_n, 1);
            tick();
        end
        start = 1'b0; proc_end = 1'b0; proc_dm_en = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_eq("drain_proc_rst_n",  proc_rst_n, 0);
        check_eq("drain_run_cycles",  run_cycles, 100);
        check_eq("drain_busy",        busy, 1);
        check_eq("drain_proc_dm_out", proc_dm_out, 0);
        check_eq("drain_c0_valid",    bus.out_valid, 0);
        check_eq("drain_c0_re",       bus.dm_re, 1);
        check_eq("drain_c0_addr",     bus.dm_addr, 32'h20);
        tick();
        check_eq("drain_c1_valid", bus.out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("full_rate_valid", bus.out_valid, 1);
            check_eq("full_rate_data",  bus.out_data, 32'(i + 1));
        end
        tick();
        check_eq("full_rate_done",  done, 1);
        check_eq("full_rate_busy",  busy, 0);
        check_eq("full_rate_valid_end", bus.out_valid, 0);

        // Backpressure with address wrap
        pulse_start(16'd2, 16'hFFFE, 16'd4);
        check_eq("restart_run_cycles", run_cycles, 0);
        check_eq("restart_done",       done, 0);
        bus.in_valid = 1'b1; bus.in_data = 8'hA1;
        tick();
        bus.in_data = 8'hA2;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            proc_dm_en = (k < 3);
            proc_ar    = (k == 1) ? 16'hFFFE : 16'hFFFF;
            proc_bus   = (k == 1) ? 24'hB1 : 24'hB2;
            proc_end   = (k == 3);
            tick();
        end
        proc_dm_en = 1'b0; proc_end = 1'b0;
        idx = 0; stalled = 1'b0; hold = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            bus.out_ready = (c >= 150) ? 1'b1 : 1'($urandom_range(1, 0));
            #1;
            if (stalled) begin
                check_eq("stall_valid", bus.out_valid, 1);
                check_eq("stall_data",  bus.out_data, hold);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (idx < 4) check_eq("wrap_data", bus.out_data, wrap_exp[idx]);
                idx++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            hold    = bus.out_data;
            tick();
        end
        check_eq("wrap_count", idx, 4);
        check_eq("wrap_done",  done, 1);

        // Zero lengths
        nw = n_writes;
        nv = n_valid;
        pulse_start(16'd0, 16'h0000, 16'd0);
        check_eq("zero_run_proc_rst_n", proc_rst_n, 1);
        check_eq("zero_run_in_ready",   bus.in_ready, 0);
        proc_end = 1'b1;
        tick();
        proc_end = 1'b0;
        check_eq("zero_drain_proc_rst_n", proc_rst_n, 0);
        check_eq("zero_drain_busy",       busy, 1);
        check_eq("zero_run_cycles",       run_cycles, 1);
        tick();
        check_eq("zero_done",    done, 1);
        check_eq("zero_busy",    busy, 0);
        check_eq("zero_writes",  n_writes, nw);
        check_eq("zero_valids",  n_valid, nv);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
